fft_frame_scheduler: RTL

Sequencing controller for the `fft_16pt` core. It collects a 16-sample frame from a streaming valid/ready source and holds it stable on the core's parallel input. It then pulses `start`, waits for `done` and captures the 16 results. Results are streamed out one per handshake, and the next frame is loaded while the previous one drains. The block sits between the sample front-end and downstream spectral consumers, replacing the free-running `start=1` drive used at bench level.

---
 rtl/fft_frame_scheduler_if.sv | 24 ++
 rtl/fft_frame_scheduler.sv | 126 ++++++++++++
 2 files changed

// File: rtl/fft_frame_scheduler_if.sv
// Sample-in / result-out stream handshakes between fft_frame_scheduler and its neighbours.
// master is the source/sink side; slave is the scheduler.
interface fft_frame_scheduler_if #(
  parameter int unsigned WIDTH = 36
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       out_index;
  logic             out_last;
  logic             out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last
  );
endinterface

// File: rtl/fft_frame_scheduler.sv
// Frame sequencer for fft_16pt: gathers 16 samples, starts the core, captures and streams
// the results while the next frame loads.
module fft_frame_scheduler #(
  parameter int unsigned WIDTH   = 36,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                 clock,
  input  logic                 reset,
  fft_frame_scheduler_if.slave bus,
  output logic [WIDTH-1:0]     fft_f [0:15],
  output logic                 fft_start,
  input  logic [WIDTH-1:0]     fft_F [0:15],
  input  logic                 fft_done,
  output logic                 busy,
  output logic                 error,
  output logic [15:0]          frame_count
);

  localparam int unsigned WcntW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WcntW-1:0] WcntMax = WcntW'(TIMEOUT);

  typedef enum logic [1:0] {StLoad, StStart, StWait, StDrain} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ibuf_q [0:15];
  logic [WIDTH-1:0] rbuf_q [0:15];
  logic [4:0]       lcnt_q, lcnt_d;
  logic [3:0]       dcnt_q, dcnt_d;
  logic [WcntW-1:0] wcnt_q, wcnt_d, wcnt_inc;
  logic [15:0]      fcnt_q, fcnt_d;
  logic             error_q, error_d;
  logic             armed_q;
  logic             fft_start_q, busy_q, out_valid_q;
  logic             in_fire, capture;

  // Holds in_ready low for the first cycle out of reset.
  always_ff @(posedge clock) begin
    if (!reset) armed_q <= 1'b0;
    else        armed_q <= 1'b1;
  end

  assign bus.in_ready = armed_q && (state_q == StLoad || state_q == StDrain) && !lcnt_q[4];
  assign in_fire      = bus.in_valid && bus.in_ready;

  // Counter holds completed WAIT cycles, so abort comes after TIMEOUT cycles in WAIT.
  assign wcnt_inc = (wcnt_q >= WcntMax) ? wcnt_q : wcnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    lcnt_d  = in_fire ? lcnt_q + 5'd1 : lcnt_q;
    dcnt_d  = dcnt_q;
    wcnt_d  = wcnt_q;
    fcnt_d  = fcnt_q;
    error_d = error_q;
    capture = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (lcnt_d[4]) state_d = StStart;
      end
      StStart: begin
        wcnt_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        wcnt_d = wcnt_inc;
        if (fft_done) begin
          capture = 1'b1;
          lcnt_d  = '0;
          dcnt_d  = '0;
          fcnt_d  = fcnt_q + 16'd1;
          state_d = StDrain;
        end else if (wcnt_inc >= WcntMax) begin
          error_d = 1'b1;
          lcnt_d  = '0;
          state_d = StLoad;
        end
      end
      StDrain: begin
        if (bus.out_ready) begin
          dcnt_d = dcnt_q + 4'd1;
          if (dcnt_q == 4'd15) state_d = lcnt_d[4] ? StStart : StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= StLoad;
      lcnt_q      <= '0;
      dcnt_q      <= '0;
      wcnt_q      <= '0;
      fcnt_q      <= '0;
      error_q     <= 1'b0;
      fft_start_q <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      ibuf_q      <= '{default: '0};
      rbuf_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      lcnt_q      <= lcnt_d;
      dcnt_q      <= dcnt_d;
      wcnt_q      <= wcnt_d;
      fcnt_q      <= fcnt_d;
      error_q     <= error_d;
      fft_start_q <= (state_d == StStart);
      busy_q      <= (state_d == StStart) || (state_d == StWait);
      out_valid_q <= (state_d == StDrain);
      if (in_fire) ibuf_q[lcnt_q[3:0]] <= bus.in_data;
      if (capture) rbuf_q <= fft_F;
    end
  end

  assign fft_f         = ibuf_q;
  assign fft_start     = fft_start_q;
  assign busy          = busy_q;
  assign error         = error_q;
  assign frame_count   = fcnt_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_valid_q ? rbuf_q[dcnt_q] : '0;
  assign bus.out_index = out_valid_q ? dcnt_q : 4'd0;
  assign bus.out_last  = out_valid_q && (dcnt_q == 4'd15);

endmodule
